// File: rtl/scan_seq3_pkg.sv
// Shared constants for the 3-bit scan sequencer: FSM encoding, scan modes
// and the two possible first codes.
package scan_seq3_pkg;

  localparam int unsigned CODE_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_PINGPONG = 2'b11;

  localparam logic [CODE_W-1:0] CODE_LO = 3'b000;
  localparam logic [CODE_W-1:0] CODE_HI = 3'b111;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts up to limit, then wraps to zero; expire flags the
// last cycle of a dwell period.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  assign expire = (count == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/scan_seq3.sv
// Programmable scan sequencer driving the {a,b,c} selects of a 3-to-8
// decoder, with per-code dwell and step/done strobes.
module scan_seq3
  import scan_seq3_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               valid,
  output logic               step,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state, state_n;
  logic [CODE_W-1:0]  code, code_n;
  logic               dir_down, dir_down_n;
  logic [1:0]         mode_q, mode_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               valid_n, step_n, busy_n, done_n;
  logic               timer_clear, timer_en, expire;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (dwell_q),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      code     <= CODE_LO;
      dir_down <= 1'b0;
      mode_q   <= MODE_UP;
      dwell_q  <= '0;
      valid    <= 1'b0;
      step     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      code     <= code_n;
      dir_down <= dir_down_n;
      mode_q   <= mode_n;
      dwell_q  <= dwell_n;
      valid    <= valid_n;
      step     <= step_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-output logic; stop outranks a dwell expiry.
  always_comb begin
    state_n     = state;
    code_n      = code;
    dir_down_n  = dir_down;
    mode_n      = mode_q;
    dwell_n     = dwell_q;
    valid_n     = 1'b0;
    step_n      = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_n     = ST_RUN;
          mode_n      = mode;
          dwell_n     = dwell;
          code_n      = (mode == MODE_DOWN) ? CODE_HI : CODE_LO;
          dir_down_n  = (mode == MODE_DOWN);
          timer_clear = 1'b1;
          valid_n     = 1'b1;
          busy_n      = 1'b1;
          step_n      = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else begin
          timer_en = 1'b1;
          valid_n  = 1'b1;
          busy_n   = 1'b1;
          if (expire) begin
            step_n = 1'b1;
            case (mode_q)
              MODE_UP:   code_n = code + 3'd1;
              MODE_DOWN: code_n = code - 3'd1;
              MODE_ONESHOT: begin
                if (code == CODE_HI) begin
                  state_n = ST_DONE;
                  done_n  = 1'b1;
                  valid_n = 1'b0;
                  busy_n  = 1'b0;
                  step_n  = 1'b0;
                end else begin
                  code_n = code + 3'd1;
                end
              end
              default: begin
                // Ping-pong turns at the endpoints so each is shown once.
                if (!dir_down) begin
                  if (code == CODE_HI) begin
                    dir_down_n = 1'b1;
                    code_n     = code - 3'd1;
                  end else begin
                    code_n = code + 3'd1;
                  end
                end else begin
                  if (code == CODE_LO) begin
                    dir_down_n = 1'b0;
                    code_n     = code + 3'd1;
                  end else begin
                    code_n = code - 3'd1;
                  end
                end
              end
            endcase
          end
        end
      end

      ST_DONE: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase
  end

  assign a = code[2];
  assign b = code[1];
  assign c = code[0];

endmodule

// File: tb/tb_scan_seq3.sv
// Scoreboard bench for scan_seq3: each scenario queues the expected
// per-cycle {code,valid,step,busy,done} and compares after every edge.
module tb_scan_seq3;

  localparam int unsigned DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [DWELL_W-1:0] dwell = '0;
  logic               a, b, c, valid, step, busy, done;

  logic [6:0] exp_q[$];
  int total = 0;
  int bad = 0;

  scan_seq3 #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dwell (dwell),
    .a     (a),
    .b     (b),
    .c     (c),
    .valid (valid),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input logic [2:0] code, input logic v,
                                    input logic s, input logic bs, input logic d);
    return {code, v, s, bs, d};
  endfunction

  // Advance one edge, sample 1 time unit later, pop the matching expectation.
  task automatic tick(output logic [6:0] obs, output logic [6:0] expv);
    @(posedge clk);
    #1;
    obs = {a, b, c, valid, step, busy, done};
    if (exp_q.size() != 0) expv = exp_q.pop_front();
    else expv = 'x;
  endtask

  task automatic test_reset;
    logic [6:0] o, e;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({a, b, c, valid, step, busy, done} !== 7'b0) begin
      bad++;
      $display("FAIL reset_init got=%b exp=%b", {a, b, c, valid, step, busy, done}, 7'b0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Mid-scan reset at code 5 (mode 00, dwell 2).
    mode = 2'b00; dwell = 8'd2; start = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(3'(k / 3), 1'b1, (k % 3) == 0, 1'b1, 1'b0));
    for (int i = 0; i < 16; i++) begin
      tick(o, e);
      start = 1'b0;
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_prerun cyc=%0d got=%b exp=%b", i, o, e); end
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({a, b, c, valid, step, busy, done} !== 7'b0) begin
      bad++;
      $display("FAIL reset_async got=%b exp=%b", {a, b, c, valid, step, busy, done}, 7'b0);
    end
    #1 rst = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(3'd0, 1'b1, k == 0, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      tick(o, e);
      start = 1'b0;
      stop = (i == 2);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_restart cyc=%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_up_wrap;
    logic [6:0] o, e;
    mode = 2'b00; dwell = 8'd2; start = 1'b1;
    for (int k = 0; k < 27; k++) exp_q.push_back(mk(3'((k / 3) % 8), 1'b1, (k % 3) == 0, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 28; i++) begin
      tick(o, e);
      start = 1'b0;
      stop = (i == 26);
      total++;
      if (o !== e) begin bad++; $display("FAIL up_wrap cyc=%0d got=%b exp=%b", i, o, e); end
    end
    stop = 1'b0;
  endtask

  task automatic test_down_zero_dwell;
    logic [6:0] o, e;
    mode = 2'b01; dwell = 8'd0; start = 1'b1;
    for (int k = 0; k < 9; k++) exp_q.push_back(mk(3'(7 - (k % 8)), 1'b1, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick(o, e);
      start = 1'b0;
      stop = (i == 8);
      total++;
      if (o !== e) begin bad++; $display("FAIL down_wrap cyc=%0d got=%b exp=%b", i, o, e); end
    end
    stop = 1'b0;
  endtask

  task automatic test_oneshot;
    logic [6:0] o, e;
    mode = 2'b10; dwell = 8'd1; start = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(3'(k / 2), 1'b1, (k % 2) == 0, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 21; i++) begin
      tick(o, e);
      start = (i == 17);
      stop = (i == 19);
      total++;
      if (o !== e) begin bad++; $display("FAIL oneshot cyc=%0d got=%b exp=%b", i, o, e); end
    end
    stop = 1'b0;
  endtask

  task automatic test_pingpong_stop;
    logic [6:0] o, e;
    logic [2:0] seq[18];
    for (int k = 0; k < 8; k++) seq[k] = 3'(k);
    for (int k = 0; k < 7; k++) seq[8 + k] = 3'(6 - k);
    seq[15] = 3'd1; seq[16] = 3'd2; seq[17] = 3'd3;
    mode = 2'b11; dwell = 8'd0; start = 1'b1;
    for (int k = 0; k < 18; k++) exp_q.push_back(mk(seq[k], 1'b1, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      tick(o, e);
      start = 1'b0;
      stop = (i == 17);
      total++;
      if (o !== e) begin bad++; $display("FAIL pingpong cyc=%0d got=%b exp=%b", i, o, e); end
    end
    stop = 1'b0;
  endtask

  task automatic test_contention;
    logic [6:0] o, e;
    // Idle with start+stop, then a run that ignores a late start/mode change.
    mode = 2'b00; dwell = 8'd0; start = 1'b1; stop = 1'b1;
    exp_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(3'(k), 1'b1, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) begin
      tick(o, e);
      if (i == 0) stop = 1'b0;
      if (i == 1) begin start = 1'b1; mode = 2'b01; dwell = 8'd5; end
      if (i == 4) begin start = 1'b0; end
      stop = (i == 5);
      total++;
      if (o !== e) begin bad++; $display("FAIL contention cyc=%0d got=%b exp=%b", i, o, e); end
    end
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_zero_dwell();
    test_oneshot();
    test_pingpong_stop();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_seq3.md
# scan_seq3

Programmable 3-bit scan sequencer that sits directly upstream of the 3-to-8 decoder (DEC3_8) and drives its `{a,b,c}` select inputs. On a start request it steps the select code through 0–7 in a chosen pattern. Each code is held for a programmable dwell time. Strobes tell downstream logic when a new code is presented and when a one-shot scan has finished.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell field and of the internal dwell counter.

Ports (`name direction width meaning`):
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- `clk` input 1: rising-edge clock for all state.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a scan; sampled only in IDLE.
- `stop` input 1: abort a scan; sampled in RUN, and also in IDLE when `start` is high.
- `mode` input 2: scan pattern, latched at start.
  - 00 = up, wrapping.
  - 01 = down, wrapping.
  - 10 = up, one-shot.
  - 11 = ping-pong.
- `dwell` input DWELL_W: each code is held for `dwell`+1 cycles; latched at start.
- `a` output 1: select MSB, to decoder `a`.
- `b` output 1: select middle bit, to decoder `b`.
- `c` output 1: select LSB, to decoder `c`.
- `valid` output 1: the presented code is an active scan step.
- `step` output 1: one-cycle pulse on every cycle a new code is first presented.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when a one-shot scan completes.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `{a,b,c}`=000, `valid`=0, `step`=0, `busy`=0, `done`=0, dwell counter 0, direction up.
- IDLE → RUN on `start`=1 and `stop`=0:
  - Latch `mode` and `dwell`.
  - Load the first code: 111 for mode 01, 000 otherwise.
  - Set direction: down for mode 01, up otherwise.
  - Clear the dwell counter.
- `start` and `stop` both high in IDLE: stay in IDLE.
- RUN, dwell counter below the latched dwell: increment the counter and hold the code.
- RUN, counter equal to the latched dwell: clear the counter and advance the code.
  - Mode 00: +1 mod 8 (7 → 0).
  - Mode 01: −1 mod 8 (0 → 7).
  - Mode 10: +1 when code < 7; at 7, go to DONE.
  - Mode 11: +1 while direction is up; at 7, direction becomes down and the next code is 6. Symmetrically, at 0 direction becomes up and the next code is 1. Endpoints are presented once per turn, not twice.
- DONE lasts one cycle:
  - `done`=1, `valid`=0, `busy`=0, code held at 111.
  - Next cycle: IDLE.
- `stop`=1 in RUN: next cycle IDLE, `valid`=0, `busy`=0, code held at its last value, no `done` pulse.
- `stop` takes priority over a dwell expiry in the same cycle.
- `start` while in RUN or DONE is ignored.
- Changes on `mode` or `dwell` during RUN have no effect until the next start.
- All arithmetic on the code is 3-bit modulo; the dwell comparison is unsigned DWELL_W-bit.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge N:
  - From edge N: first code on `{a,b,c}`, `valid`=1, `busy`=1, `step`=1.
- Each code is held exactly `dwell`+1 cycles.
- `step` pulses on the first cycle of every code, including the first.
- `dwell`=0: the code changes every cycle and `step` stays continuously high.
- Mode 10, full scan: 8×(`dwell`+1) cycles in RUN, then one DONE cycle, then IDLE.
  - A new `start` is accepted from the first IDLE cycle.
- `stop` sampled at edge M: `valid`, `busy` and `step` are low from edge M.
- `rst` asserted at any time, including mid-scan: all outputs return to reset values immediately (asynchronously).
  - After deassertion, the first rising edge evaluates from IDLE.

## Structure
- Package `scan_seq3_pkg` holds:
  - The state encoding: IDLE, RUN, DONE.
  - The mode constants: MODE_UP, MODE_DOWN, MODE_ONESHOT, MODE_PINGPONG.
  - The first-code constants: 000 and 111.
- Sub-module `dwell_timer`:
  - Parameter DWELL_W.
  - Inputs: `clear`, `enable`, `limit`.
  - Output: `expire`, high when the count equals `limit`.
  - All other logic (FSM, code/direction registers, output registers) stays in `scan_seq3`.

## Test plan
- Reset mid-scan: mode 00, `dwell`=2, assert `rst` at code 5 → outputs immediately 000, `valid`=0, `busy`=0; a restart begins at 000.
- Up wrap: mode 00, `dwell`=2, `start` → codes 0..7 then 0, each held 3 cycles; `step` high on 9 cycles, 3 apart.
- Down wrap with zero dwell: mode 01, `dwell`=0 → codes 7,6,…,0,7 on consecutive cycles; `step` constantly high.
- One-shot: mode 10, `dwell`=1 → 16 RUN cycles; `done` high for exactly 1 cycle with code 111; then `busy`=0, and a second `start` is accepted.
- Ping-pong plus stop: mode 11, `dwell`=0 → sequence 0..7,6..0,1; `stop` at code 3 → next cycle `valid`=0, code holds 011, no `done`.
- Start/stop contention: in IDLE, `start` and `stop` together → stays IDLE. In RUN, a new `start` with a different mode → sequence unchanged.
